// File: rtl/ibus_pkg.sv
// ibus_pkg: shared definitions for the ibus control target.
//   - bus width
//   - register offsets inside the decoded window
//   - CTRL / STATUS bit positions
//   - sequencer state encoding
//   - run_cycles(): cycles a command occupies in RUN
package ibus_pkg;

    localparam int unsigned BusW = 16;

    // Register offsets within the window
    localparam logic [BusW-1:0] OffCtrl    = 16'd0;
    localparam logic [BusW-1:0] OffStatus  = 16'd1;
    localparam logic [BusW-1:0] OffCmd     = 16'd2;
    localparam logic [BusW-1:0] OffDoneCnt = 16'd3;
    localparam logic [BusW-1:0] OffScratch = 16'd4;

    // CTRL bits
    localparam int unsigned CtrlEnableBit  = 0;
    localparam int unsigned CtrlIrqEnBit   = 1;
    localparam int unsigned CtrlSoftClrBit = 15;

    // STATUS bits
    localparam int unsigned StatBusyBit  = 0;
    localparam int unsigned StatEmptyBit = 1;
    localparam int unsigned StatFullBit  = 2;
    localparam int unsigned StatDoneBit  = 3;
    localparam int unsigned StatCntLsb   = 4;
    localparam int unsigned StatCntW     = 3;
    localparam int unsigned StatOvfBit   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } seq_state_e;

    // A zero command still runs for one cycle.
    function automatic logic [BusW-1:0] run_cycles(input logic [BusW-1:0] cmd);
        return (cmd == '0) ? 16'd1 : cmd;
    endfunction

endpackage

// File: rtl/ibus_cmd_fifo.sv
// ibus_cmd_fifo: synchronous FIFO holding queued run commands.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the FIFO at the next edge; a same-cycle push is discarded
//   push/din : write request and data; accepted when not full, or when full with a pop
//   pop      : removes the head; ignored when empty
//   dout     : current head (valid only when !empty)
//   full, empty, count : occupancy (count is 0..2**FIFO_AW)
module ibus_cmd_fifo #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    logic [WIDTH-1:0]   mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q;
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop) && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/ibus_ctrl_target.sv
// ibus_ctrl_target: ibus responder with control/status/scratch registers,
// a command FIFO and a run sequencer.
//   clk, rst              : clock, synchronous active-high reset
//   ren, ibus_radr        : read strobe and word address
//   ibus_rdata            : registered read data, 0 when not selected (OR-combinable)
//   wen, ibus_wadr, ibus_wdata : write strobe, word address, data
//   run_active            : high while a command is running
//   run_cmd               : command currently (or last) executed
//   done_pulse            : one-cycle pulse after each completed run
//   irq                   : CTRL.irq_en & STATUS.done_sticky
module ibus_ctrl_target
    import ibus_pkg::*;
#(
    parameter logic [15:0] BASE_ADR = 16'hF000,
    parameter int unsigned WIN_BITS = 3,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ren,
    input  logic [BusW-1:0] ibus_radr,
    output logic [BusW-1:0] ibus_rdata,
    input  logic            wen,
    input  logic [BusW-1:0] ibus_wadr,
    input  logic [BusW-1:0] ibus_wdata,
    output logic            run_active,
    output logic [BusW-1:0] run_cmd,
    output logic            done_pulse,
    output logic            irq
);

    localparam logic [BusW-1:0] WinMask = BusW'((32'd1 << WIN_BITS) - 32'd1);
    localparam logic [BusW-1:0] WinTag  = BASE_ADR >> WIN_BITS;

    // Address decode
    logic            rd_hit;
    logic            wr_hit;
    logic [BusW-1:0] rd_off;
    logic [BusW-1:0] wr_off;
    logic            wr_ctrl;
    logic            wr_status;
    logic            wr_cmd;
    logic            wr_scratch;
    logic            soft_clear;

    assign rd_hit = ((ibus_radr >> WIN_BITS) == WinTag);
    assign wr_hit = ((ibus_wadr >> WIN_BITS) == WinTag);
    assign rd_off = ibus_radr & WinMask;
    assign wr_off = ibus_wadr & WinMask;

    assign wr_ctrl    = wen && wr_hit && (wr_off == OffCtrl);
    assign wr_status  = wen && wr_hit && (wr_off == OffStatus);
    assign wr_cmd     = wen && wr_hit && (wr_off == OffCmd);
    assign wr_scratch = wen && wr_hit && (wr_off == OffScratch);
    assign soft_clear = wr_ctrl && ibus_wdata[CtrlSoftClrBit];

    // Registers
    logic            enable_q;
    logic            irq_en_q;
    logic [BusW-1:0] scratch_q;
    logic [BusW-1:0] done_cnt_q;
    logic            done_sticky_q;
    logic            ovf_q;
    logic [BusW-1:0] rdata_q;

    // Sequencer
    seq_state_e      state_q;
    logic [BusW-1:0] cnt_q;
    logic [BusW-1:0] run_cmd_q;
    logic            run_active_q;
    logic            done_pulse_q;

    // FIFO
    logic            fifo_push;
    logic            fifo_pop;
    logic [BusW-1:0] fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    logic            done_evt;
    logic            ovf_evt;
    logic [BusW-1:0] status;
    logic [BusW-1:0] rd_val;

    assign fifo_push = wr_cmd && !soft_clear;
    assign fifo_pop  = (state_q == StLoad);

    ibus_cmd_fifo #(
        .WIDTH   (BusW),
        .FIFO_AW (FIFO_AW)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (soft_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ibus_wdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // DONE-cycle bookkeeping is suppressed when a soft clear lands on it.
    assign done_evt = (state_q == StDone) && !soft_clear;
    assign ovf_evt  = fifo_push && fifo_full && !fifo_pop;

    always_comb begin
        status = '0;
        status[StatBusyBit]                  = (state_q != StIdle);
        status[StatEmptyBit]                 = fifo_empty;
        status[StatFullBit]                  = fifo_full;
        status[StatDoneBit]                  = done_sticky_q;
        status[StatCntLsb +: StatCntW]       = StatCntW'(fifo_count);
        status[StatOvfBit]                   = ovf_q;
    end

    always_comb begin
        rd_val = '0;
        case (rd_off)
            OffCtrl: begin
                rd_val[CtrlEnableBit] = enable_q;
                rd_val[CtrlIrqEnBit]  = irq_en_q;
            end
            OffStatus:  rd_val = status;
            OffCmd:     rd_val = fifo_empty ? '0 : fifo_dout;
            OffDoneCnt: rd_val = done_cnt_q;
            OffScratch: rd_val = scratch_q;
            default:    rd_val = '0;
        endcase
    end

    // Read data reflects pre-edge register values, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= (ren && rd_hit) ? rd_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            scratch_q     <= '0;
            done_cnt_q    <= '0;
            done_sticky_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= ibus_wdata[CtrlEnableBit];
                irq_en_q <= ibus_wdata[CtrlIrqEnBit];
            end
            if (wr_scratch) begin
                scratch_q <= ibus_wdata;
            end
            if (done_evt) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
            // Set has priority over write-1-to-clear.
            if (done_evt) begin
                done_sticky_q <= 1'b1;
            end else if (wr_status && ibus_wdata[StatDoneBit]) begin
                done_sticky_q <= 1'b0;
            end
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (wr_status && ibus_wdata[StatOvfBit]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_clear) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            run_cmd_q    <= '0;
            run_active_q <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable_q && !fifo_empty) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    run_cmd_q    <= fifo_dout;
                    cnt_q        <= run_cycles(fifo_dout);
                    run_active_q <= 1'b1;
                    state_q      <= StRun;
                end
                StRun: begin
                    if (cnt_q == 16'd1) begin
                        cnt_q        <= '0;
                        run_active_q <= 1'b0;
                        done_pulse_q <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StDone: begin
                    done_pulse_q <= 1'b0;
                    state_q      <= (enable_q && !fifo_empty) ? StLoad : StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ibus_rdata = rdata_q;
    assign run_active = run_active_q;
    assign run_cmd    = run_cmd_q;
    assign done_pulse = done_pulse_q;
    assign irq        = irq_en_q && done_sticky_q;

endmodule

// File: doc/ibus_ctrl_target.md
Name: ibus_ctrl_target

Overview:
- Responder (target) end of the 16-bit ibus read/write interface (ren/ibus_radr/ibus_rdata, wen/ibus_wadr/ibus_wdata).
- Decodes an address window and holds control/status/scratch registers.
- Buffers run commands in a small FIFO; a sequencer executes each command as a timed run and reports completion.
- Sits beside the systolic array on the same ibus as the control/launch target; its output is OR-combinable with other targets.

Parameters:
- BASE_ADR, 16'hF000, base word address of the register window (aligned to window size).
- WIN_BITS, 3, window = 2**WIN_BITS words; hit = (adr >> WIN_BITS) == (BASE_ADR >> WIN_BITS).
- FIFO_AW, 2, command FIFO depth = 2**FIFO_AW (4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ren  in  1  read strobe, single-cycle.
- ibus_radr  in  16  read word address.
- ibus_rdata  out  16  registered read data.
- wen  in  1  write strobe, single-cycle.
- ibus_wadr  in  16  write word address.
- ibus_wdata  in  16  write data.
- run_active  out  1  high while the sequencer is in RUN.
- run_cmd  out  16  command currently executing.
- done_pulse  out  1  one-cycle pulse at end of each run.
- irq  out  1  level interrupt = CTRL.irq_en & STATUS.done_sticky.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; registers 0; FIFO empty; state IDLE; sticky bits clear.
- Register map (offset in window):
  - 0 CTRL RW: [0] enable, [1] irq_en, [15] soft_clear (write-1, self-clears, reads 0).
  - 1 STATUS: [0] busy (state != IDLE), [1] fifo_empty, [2] fifo_full, [3] done_sticky, [6:4] fifo count (0..4), [8] overflow_sticky. Writing 1 to bit 3 or 8 clears that bit; other bits are RO.
  - 2 CMD: write pushes wdata. Read returns FIFO head without pop, or 0 if empty.
  - 3 DONE_CNT RO: completed-run count, wraps 16'hFFFF -> 0.
  - 4 SCRATCH RW.
  - 5..7: read 0, writes ignored.
- Read timing:
  - ibus_rdata updates every cycle. Next-cycle value = selected register if (ren & hit), else 16'h0.
  - Latency 1 cycle; no stall.
  - A read and write to the same register in one cycle returns the pre-write value.
- Writes take effect at the posedge where wen & hit. Simultaneous ren and wen to different addresses are both serviced.
- FIFO:
  - Push when not full is accepted.
  - Push when full with a same-cycle pop is accepted.
  - Push when full without a pop is dropped and sets overflow_sticky.
  - Pointers wrap modulo depth.
- Sequencer states:
  - IDLE: if enable & !empty -> LOAD.
  - LOAD (1 cycle): pop head into run_cmd; load counter = max(cmd,1) -> RUN.
  - RUN: run_active=1; decrement counter each cycle; at counter==1 -> DONE. A run lasts exactly max(cmd,1) cycles.
  - DONE (1 cycle): done_pulse=1; DONE_CNT+1; set done_sticky. Next state is LOAD if enable & !empty, else IDLE.
- Clearing enable mid-run: the current run completes; no new LOAD.
- soft_clear (any state): at the next posedge, FIFO flushes, state -> IDLE, run_cmd=0, counter=0, no done_pulse, DONE_CNT unchanged. A same-cycle CMD push is discarded.
- done_sticky set and W1C in the same cycle: set wins.

Decomposition:
- Shared package ibus_pkg:
  - register offsets (CTRL/STATUS/CMD/DONE_CNT/SCRATCH);
  - CTRL/STATUS bit positions;
  - sequencer state encoding (IDLE/LOAD/RUN/DONE);
  - bus width 16.
- One sub-module, ibus_cmd_fifo: synchronous FIFO parameterised by width and FIFO_AW. Ports push, pop, din, dout (head), full, empty, count, flush.
- The address decode, register bank and sequencer stay in ibus_ctrl_target.

Test Plan:
- Reset, then read every offset 0..7 at BASE_ADR+n -> rdata one cycle later: STATUS=16'h0002, all others 0. Read of 16'h1234 (miss) -> rdata 0.
- Write SCRATCH=16'hA5C3, then read SCRATCH and CTRL back-to-back -> 16'hA5C3 then 16'h0000. Same-cycle write 16'h1111 and read of SCRATCH -> read returns 16'hA5C3.
- enable=0; push 3,0,5,7,9 -> fifo_full, count=4, overflow_sticky=1; CMD read = 3. Set enable -> runs of 3,1,5,7 cycles, each followed by one done_pulse. DONE_CNT=4, fifo_empty=1.
- irq_en=1 after one run -> irq=1. W1C STATUS bit 3 -> irq=0 next cycle. If the clear coincides with a done_pulse -> done_sticky stays 1.
- Push 16'd100, enable, write soft_clear at run cycle 10 -> run_active=0 next cycle, no done_pulse, DONE_CNT unchanged, fifo empty, CTRL reads 0x0001.
- Full FIFO during RUN, push in the exact DONE->LOAD pop cycle -> accepted, overflow_sticky stays 0. Preload DONE_CNT to 16'hFFFF via 65535 one-cycle runs (or force) -> one more run wraps it to 0.
